// File: rtl/bi2uni_pkg.sv
// rtl/bi2uni_pkg.sv - shared types and helpers for the bipolar-to-unipolar converter
package bi2uni_pkg;

  // Per-cycle update decision taken by the converter
  typedef enum logic [2:0] {
    HOLD,   // no accepted input this cycle
    EMIT,   // input 1 with no debt: pass a 1 through
    DEC,    // input 1 cancels one stored surplus 0
    INC,    // input 0 stored as surplus
    CLIP,   // input 0 dropped because the debt store is full
    FLUSH   // synchronous clear back to the initial debt
  } action_e;

  // Largest debt a DEPTH-bit counter can hold
  function automatic int dmax(input int depth);
    return (1 << depth) - 1;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down counter with sync load and full/empty flags
module sat_updown_cnt #(
  parameter int WIDTH = 4,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: load wins, then single-direction steps that stop at either end
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = INIT_V;
    end else if (inc && !dec && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, returns to the initial value on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= INIT_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign full  = (cnt_q == MAX_V);
  assign empty = (cnt_q == '0);

  a_no_wrap_up: assert property (@(posedge clk) disable iff (rst)
    (!load && inc && !dec && full) |=> full);
  a_no_wrap_dn: assert property (@(posedge clk) disable iff (rst)
    (!load && dec && !inc && empty) |=> empty);

endmodule

// File: rtl/bi2uni.sv
// rtl/bi2uni.sv - converts a bipolar stochastic bitstream to a clipped unipolar bitstream
module bi2uni
  import bi2uni_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INIT_DEBT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr,
  output logic             out_valid,
  output logic             out,
  output logic             sat,
  output logic [DEPTH-1:0] debt
);

  localparam int DMAX = dmax(DEPTH);

  if (INIT_DEBT < 0 || INIT_DEBT > DMAX) begin : g_bad_init
    $error("bi2uni: INIT_DEBT must lie in [0, 2**DEPTH-1]");
  end

  action_e action;
  logic    cnt_full;
  logic    cnt_empty;
  logic    out_d, out_q;
  logic    out_valid_d, out_valid_q;

  // Pick this cycle's action; each stored 0 must be paid off by a later 1 before a 1 passes
  always_comb begin
    action = HOLD;
    if (clr) begin
      action = FLUSH;
    end else if (!in_valid) begin
      action = HOLD;
    end else if (in) begin
      action = cnt_empty ? EMIT : DEC;
    end else begin
      action = cnt_full ? CLIP : INC;
    end
    out_d       = (action == EMIT);
    out_valid_d = (action inside {EMIT, DEC, INC, CLIP});
  end

  sat_updown_cnt #(
    .WIDTH (DEPTH),
    .INIT  (INIT_DEBT)
  ) u_debt (
    .clk   (clk),
    .rst   (rst),
    .load  (action == FLUSH),
    .inc   (action == INC),
    .dec   (action == DEC),
    .cnt   (debt),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

  // Output stage: one cycle of latency from accepted input to out/out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat       = cnt_full;

endmodule

// File: tb/tb_bi2uni.sv
// tb/tb_bi2uni.sv - randomized and directed self-checking bench for bi2uni
module tb_bi2uni;

  localparam int DEPTH     = 4;
  localparam int INIT_DEBT = 0;
  localparam int DMAX      = (1 << DEPTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_b = 1'b0;
  logic             clr = 1'b0;
  logic             out_valid;
  logic             out;
  logic             sat;
  logic [DEPTH-1:0] debt;

  int total = 0;
  int bad   = 0;

  // reference state
  int m_debt = INIT_DEBT;
  int m_out  = 0;
  int m_ov   = 0;
  int m_clips = 0;

  // observation of the DUT stream
  int ones_seen = 0;
  int last_out  = 0;
  int max_debt  = 0;
  int sat_seen  = 0;

  bi2uni #(.DEPTH(DEPTH), .INIT_DEBT(INIT_DEBT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_b),
    .clr       (clr),
    .out_valid (out_valid),
    .out       (out),
    .sat       (sat),
    .debt      (debt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: debt is a clamped integer; a 1 passes only when no 0s are owed
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_debt = INIT_DEBT;
      m_out  = 0;
      m_ov   = 0;
    end else if (clr) begin
      m_debt = INIT_DEBT;
      m_out  = 0;
      m_ov   = 0;
    end else if (!in_valid) begin
      m_out = 0;
      m_ov  = 0;
    end else begin
      m_ov  = 1;
      m_out = (in_b && m_debt == 0) ? 1 : 0;
      if (!in_b && m_debt == DMAX) m_clips++;
      m_debt = in_b ? ((m_debt - 1 < 0) ? 0 : m_debt - 1)
                    : ((m_debt + 1 > DMAX) ? DMAX : m_debt + 1);
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("debt", int'(debt), m_debt);
    chk("sat", int'(sat), (m_debt == DMAX) ? 1 : 0);
    chk("out_valid", int'(out_valid), m_ov);
    chk("out", int'(out), m_out);
    if (out_valid && out) ones_seen++;
    if (out_valid) last_out = int'(out);
    if (int'(debt) > max_debt) max_debt = int'(debt);
    if (sat) sat_seen++;
  end

  // Drive one cycle's inputs just after the falling edge
  task automatic cyc(input logic v, input logic b, input logic c);
    @(negedge clk);
    #1;
    in_valid = v;
    in_b     = b;
    clr      = c;
  endtask

  initial begin
    int base;
    int cbase;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_debt", int'(debt), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_ov", int'(out_valid), 0);
    rst = 1'b0;

    // all ones: every one passes
    base = ones_seen;
    for (int i = 0; i < 16; i++) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("ones16_count", ones_seen - base, 16);
    chk("ones16_maxdebt", max_debt, 0);

    // 1,1,1,0 repeated: first group emits three ones, each later group two
    base = ones_seen;
    sat_seen = 0;
    for (int i = 0; i < 64; i++) cyc(1, (i % 4) != 3, 0);
    cyc(0, 0, 0);
    chk("p75_count", ones_seen - base, 33);
    chk("p75_maxdebt", max_debt, 1);
    chk("p75_sat", sat_seen, 0);

    // 20 zeros then 16 ones
    cyc(0, 0, 1);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("z15_debt", int'(debt), 15);
    chk("z15_sat", int'(sat), 1);
    cbase = m_clips;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("clip_count", m_clips - cbase, 5);
    chk("clip_debt", int'(debt), 15);
    base = ones_seen;
    for (int i = 0; i < 16; i++) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("payoff_ones", ones_seen - base, 1);
    chk("payoff_last", last_out, 1);
    chk("payoff_debt", int'(debt), 0);

    // valid toggling from debt 3
    cyc(0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("tog_debt1", int'(debt), 2);
    cyc(1, 1, 0);
    chk("tog_debt2", int'(debt), 2);
    chk("tog_ov2", int'(out_valid), 0);
    chk("tog_out2", int'(out), 0);
    cyc(0, 1, 0);
    chk("tog_debt3", int'(debt), 1);

    // clr beats a concurrent zero
    cyc(0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("clr_pre", int'(debt), 7);
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    chk("clr_debt", int'(debt), INIT_DEBT);
    chk("clr_ov", int'(out_valid), 0);
    cyc(0, 0, 0);
    chk("clr_then_one", int'(out), 1);
    chk("clr_then_ov", int'(out_valid), 1);

    // asynchronous reset between edges
    cyc(0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0);
    @(posedge clk);
    #2;
    chk("arst_pre_debt", int'(debt), 9);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_debt", int'(debt), 0);
    chk("arst_ov", int'(out_valid), 0);
    chk("arst_out", int'(out), 0);
    #1;
    rst = 1'b0;
    base = ones_seen;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("arst_resume", ones_seen - base, 3);

    // randomized bias sweep
    for (int blk = 0; blk < 12; blk++) begin
      int pct;
      pct = 20 + 10 * int'($urandom_range(7));
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(3) != 0, int'($urandom_range(99)) < pct,
            $urandom_range(63) == 0);
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
